// File: rtl/bio_pkg.sv
// Shared definitions for the BIO GPIO input conditioner.
package bio_pkg;

  // Default pin count and filter-count width.
  localparam int NPIN_DEF = 32;
  localparam int FCW_DEF  = 4;

  // Width of the length field carried in filt_cfg_t.
  // The per-pin counter width (FCW) must not exceed this.
  localparam int FLEN_W = 8;

  // Per-pin filter configuration as seen by one filter bit.
  typedef struct packed {
    logic              en;
    logic [FLEN_W-1:0] len;
  } filt_cfg_t;

endpackage

// File: rtl/bio_gpio_in_filter_if.sv
// Signal bundle for the GPIO input conditioner.
// Pads and configuration are driven from the host side.
// The filtered vector, events, status and interrupt come back from the device side.
interface bio_gpio_in_filter_if #(
  parameter int NPIN = 32,
  parameter int FCW  = 4
) ();

  logic [NPIN-1:0] pad_in;
  logic [NPIN-1:0] cfg_filt_en;
  logic [FCW-1:0]  cfg_filt_len;
  logic [NPIN-1:0] cfg_irq_rise;
  logic [NPIN-1:0] cfg_irq_fall;
  logic [NPIN-1:0] sts_clr;
  logic [NPIN-1:0] gpio_in;
  logic [NPIN-1:0] rise_evt;
  logic [NPIN-1:0] fall_evt;
  logic [NPIN-1:0] rise_sts;
  logic [NPIN-1:0] fall_sts;
  logic            edge_irq;

  modport master (
    output pad_in, cfg_filt_en, cfg_filt_len, cfg_irq_rise, cfg_irq_fall, sts_clr,
    input  gpio_in, rise_evt, fall_evt, rise_sts, fall_sts, edge_irq
  );

  modport slave (
    input  pad_in, cfg_filt_en, cfg_filt_len, cfg_irq_rise, cfg_irq_fall, sts_clr,
    output gpio_in, rise_evt, fall_evt, rise_sts, fall_sts, edge_irq
  );

endinterface

// File: rtl/bio_gpio_filt_bit.sv
// One conditioned GPIO pin. Each pin has:
//  - a two-flop synchroniser,
//  - a glitch-filter counter,
//  - edge-event pulses,
//  - sticky rise/fall status.
module bio_gpio_filt_bit import bio_pkg::*; #(
  parameter int FCW = FCW_DEF
) (
  input  logic      aclk,
  input  logic      reset,
  input  logic      pad,
  input  filt_cfg_t cfg,
  input  logic      sts_clr,
  output logic      gpio,
  output logic      rise_evt,
  output logic      fall_evt,
  output logic      rise_sts,
  output logic      fall_sts
);

  logic           s1_reg;
  logic           s2_reg;
  logic           gpio_reg;
  logic           gpio_next;
  logic           rise_reg;
  logic           rise_next;
  logic           fall_reg;
  logic           fall_next;
  logic           rise_sts_reg;
  logic           fall_sts_reg;
  logic           flip;
  logic [FCW-1:0] cnt_reg;
  logic [FCW-1:0] cnt_next;

  // Filter decision.
  // The counter only runs while the synchronised input disagrees with the output.
  // The output flips once the count has reached the length.
  // Using >= means a length lowered mid-count flips on the next mismatch.
  always_comb begin
    flip     = 1'b0;
    cnt_next = cnt_reg;
    if (s2_reg == gpio_reg) begin
      cnt_next = '0;
    end else if (!cfg.en || (FLEN_W'(cnt_reg) >= cfg.len)) begin
      flip     = 1'b1;
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
    gpio_next = flip ? s2_reg : gpio_reg;
    rise_next = flip & s2_reg;
    fall_next = flip & ~s2_reg;
  end

  // Two-flop synchroniser for the asynchronous pad; nothing between the flops.
  always_ff @(posedge aclk) begin
    if (reset) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= pad;
      s2_reg <= s1_reg;
    end
  end

  // Output, counter, event and sticky state.
  // A set of a sticky bit beats a simultaneous clear.
  always_ff @(posedge aclk) begin
    if (reset) begin
      gpio_reg     <= 1'b0;
      cnt_reg      <= '0;
      rise_reg     <= 1'b0;
      fall_reg     <= 1'b0;
      rise_sts_reg <= 1'b0;
      fall_sts_reg <= 1'b0;
    end else begin
      gpio_reg     <= gpio_next;
      cnt_reg      <= cnt_next;
      rise_reg     <= rise_next;
      fall_reg     <= fall_next;
      rise_sts_reg <= rise_next | (rise_sts_reg & ~sts_clr);
      fall_sts_reg <= fall_next | (fall_sts_reg & ~sts_clr);
    end
  end

  assign gpio     = gpio_reg;
  assign rise_evt = rise_reg;
  assign fall_evt = fall_reg;
  assign rise_sts = rise_sts_reg;
  assign fall_sts = fall_sts_reg;

endmodule

// File: rtl/bio_gpio_in_filter.sv
// GPIO input conditioner in front of the BIO gpio_in pins.
// It places one filter bit per pin and builds a single maskable edge interrupt.
module bio_gpio_in_filter import bio_pkg::*; #(
  parameter int NPIN = NPIN_DEF,
  parameter int FCW  = FCW_DEF
) (
  input  logic            aclk,
  input  logic            reset,
  input  logic [NPIN-1:0] pad_in,
  input  logic [NPIN-1:0] cfg_filt_en,
  input  logic [FCW-1:0]  cfg_filt_len,
  input  logic [NPIN-1:0] cfg_irq_rise,
  input  logic [NPIN-1:0] cfg_irq_fall,
  input  logic [NPIN-1:0] sts_clr,
  output logic [NPIN-1:0] gpio_in,
  output logic [NPIN-1:0] rise_evt,
  output logic [NPIN-1:0] fall_evt,
  output logic [NPIN-1:0] rise_sts,
  output logic [NPIN-1:0] fall_sts,
  output logic            edge_irq
);

  logic edge_irq_reg;
  logic edge_irq_next;

  generate
    for (genvar gi = 0; gi < NPIN; gi++) begin : g_pin
      filt_cfg_t pin_cfg;
      assign pin_cfg.en  = cfg_filt_en[gi];
      assign pin_cfg.len = FLEN_W'(cfg_filt_len);

      bio_gpio_filt_bit #(.FCW(FCW)) u_bit (
        .aclk     (aclk),
        .reset    (reset),
        .pad      (pad_in[gi]),
        .cfg      (pin_cfg),
        .sts_clr  (sts_clr[gi]),
        .gpio     (gpio_in[gi]),
        .rise_evt (rise_evt[gi]),
        .fall_evt (fall_evt[gi]),
        .rise_sts (rise_sts[gi]),
        .fall_sts (fall_sts[gi])
      );
    end
  endgenerate

  assign edge_irq_next = |((rise_sts & cfg_irq_rise) | (fall_sts & cfg_irq_fall));

  // Register the interrupt level.
  // It trails the sticky bits by one cycle.
  always_ff @(posedge aclk) begin
    if (reset) begin
      edge_irq_reg <= 1'b0;
    end else begin
      edge_irq_reg <= edge_irq_next;
    end
  end

  assign edge_irq = edge_irq_reg;

endmodule
